// File: rtl/hcsr04_echo_emulator.sv
// hcsr04_echo_emulator
//   Synthesizable HC-SR04 model. It watches the trig pulse from the measurement
//   block and answers with an Echo pulse whose width encodes a programmed
//   target distance. It is used both in simulation and as an on-board
//   loopback target.
//
// Optional build macro:
//   ECHO_JITTER_EN - when defined, a 16-bit Fibonacci LFSR adds 0..255 extra
//                    echo cycles per measurement. When undefined, the echo
//                    width is exact.
//
// Ports:
//   sys_clk50m  in   1   system clock, 50 MHz
//   sys_rst     in   1   asynchronous active-high reset
//   trig        in   1   trigger from the measurement block (asynchronous)
//   dist_cm     in   16  target distance in cm, sampled at trig acceptance
//   echo        out  1   emulated Echo line
//   busy        out  1   high from trig acceptance until the end of holdoff
//   trig_err    out  1   one-cycle pulse when trig is rejected as too short
//   dist_lat    out  16  distance latched for the current/last measurement
module hcsr04_echo_emulator #(
    parameter int unsigned TRIG_MIN_CYC  = 500,
    parameter int unsigned BURST_DLY_CYC = 10_000,
    parameter int unsigned CYC_PER_CM    = 2942,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned TIMEOUT_CYC   = 1_900_000,
    parameter int unsigned HOLDOFF_CYC   = 500_000
) (
    input  logic        sys_clk50m,
    input  logic        sys_rst,
    input  logic        trig,
    input  logic [15:0] dist_cm,
    output logic        echo,
    output logic        busy,
    output logic        trig_err,
    output logic [15:0] dist_lat
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG_HI = 3'd1;
    localparam logic [2:0] BURST   = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    localparam logic [15:0] TRIG_MIN  = 16'(TRIG_MIN_CYC);
    localparam logic [19:0] BURST_END = 20'(BURST_DLY_CYC - 1);
    localparam logic [19:0] HOLD_END  = 20'(HOLDOFF_CYC - 1);
    localparam logic [11:0] SUB_END   = 12'(CYC_PER_CM - 1);
    localparam logic [15:0] MAX_D     = 16'(MAX_CM);
    localparam logic [20:0] TMO_END   = 21'(TIMEOUT_CYC - 1);

    logic [2:0]  trig_sync;
    logic        sync_rise;
    logic        sync_fall;
    logic [2:0]  state;
    logic [15:0] wcnt;
    logic [19:0] dly_cnt;
    logic [11:0] sub_cnt;
    logic [15:0] cm_cnt;
    logic [20:0] tmo_cnt;
    logic [15:0] tgt_cm_m1;
    logic        out_of_range;
    logic        w_done;
    logic        accept;
    logic        echo_end;

    assign sync_rise = trig_sync[1] & ~trig_sync[2];
    assign sync_fall = ~trig_sync[1] & trig_sync[2];

    // wcnt is loaded with 1 on the rise-detect cycle, so at the fall-detect
    // cycle it equals the number of cycles the synchronized trig was high.
    assign accept = (state == TRIG_HI) && sync_fall && (wcnt >= TRIG_MIN);

    // Zero distance is clamped to 1 cm.
    assign tgt_cm_m1    = (dist_lat == 16'd0) ? 16'd0 : dist_lat - 16'd1;
    assign out_of_range = dist_lat > MAX_D;

    // Last cycle of the nominal echo width: cm_cnt/sub_cnt together count
    // j = cm_cnt*CYC_PER_CM + sub_cnt cycles since echo rose.
    assign w_done = out_of_range ? (tmo_cnt == TMO_END)
                                 : ((sub_cnt == SUB_END) && (cm_cnt == tgt_cm_m1));

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [7:0]  jit_len;
    logic [7:0]  jit_cnt;
    logic        in_jit;

    // Taps 16,14,13,11 (bits 15,13,12,10).
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // The jitter phase runs after the nominal width for jit_len extra cycles.
    assign echo_end = in_jit ? (jit_cnt == jit_len) : (w_done && (jit_len == 8'd0));

    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst) begin
            lfsr    <= 16'hACE1;
            jit_len <= 8'd0;
            jit_cnt <= 8'd0;
            in_jit  <= 1'b0;
        end else begin
            if (accept) begin
                lfsr    <= lfsr_nxt;
                jit_len <= lfsr_nxt[7:0];
            end
            if (state == ECHO) begin
                if (in_jit) begin
                    if (jit_cnt == jit_len)
                        in_jit <= 1'b0;
                    else
                        jit_cnt <= jit_cnt + 8'd1;
                end else if (w_done && (jit_len != 8'd0)) begin
                    in_jit  <= 1'b1;
                    jit_cnt <= 8'd1;
                end
            end
        end
    end
`else
    assign echo_end = w_done;
`endif

    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst) begin
            trig_sync <= 3'b000;
            state     <= IDLE;
            wcnt      <= 16'd0;
            dly_cnt   <= 20'd0;
            sub_cnt   <= 12'd0;
            cm_cnt    <= 16'd0;
            tmo_cnt   <= 21'd0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
            dist_lat  <= 16'd0;
        end else begin
            trig_sync <= {trig_sync[1:0], trig};
            trig_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge-based: a trig already high when holdoff ends
                    // never produces a rise here.
                    if (sync_rise) begin
                        state <= TRIG_HI;
                        wcnt  <= 16'd1;
                    end
                end
                TRIG_HI: begin
                    if (sync_fall) begin
                        if (accept) begin
                            dist_lat <= dist_cm;
                            busy     <= 1'b1;
                            dly_cnt  <= 20'd1;
                            state    <= BURST;
                        end else begin
                            trig_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end else if (wcnt != 16'hFFFF) begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                BURST: begin
                    // dly_cnt is 1 in the cycle after fall detect, so echo
                    // rises exactly BURST_DLY_CYC cycles after it.
                    if (dly_cnt == BURST_END) begin
                        echo    <= 1'b1;
                        sub_cnt <= 12'd0;
                        cm_cnt  <= 16'd0;
                        tmo_cnt <= 21'd0;
                        state   <= ECHO;
                    end else begin
                        dly_cnt <= dly_cnt + 20'd1;
                    end
                end
                ECHO: begin
                    if (echo_end) begin
                        echo    <= 1'b0;
                        dly_cnt <= 20'd0;
                        state   <= HOLDOFF;
                    end else begin
                        if (sub_cnt == SUB_END) begin
                            sub_cnt <= 12'd0;
                            cm_cnt  <= cm_cnt + 16'd1;
                        end else begin
                            sub_cnt <= sub_cnt + 12'd1;
                        end
                        tmo_cnt <= tmo_cnt + 21'd1;
                    end
                end
                HOLDOFF: begin
                    // dly_cnt is 0 in the first echo-low cycle.
                    if (dly_cnt == HOLD_END) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        dly_cnt <= dly_cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
module tb_hcsr04_echo_emulator;

    localparam int TMIN  = 20;
    localparam int BDLY  = 50;
    localparam int CPC   = 7;
    localparam int MAXC  = 40;
    localparam int TMO   = 400;
    localparam int HOLD  = 100;

    logic        sys_clk50m = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        trig       = 1'b0;
    logic [15:0] dist_cm    = 16'd0;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic [15:0] dist_lat;

    int checks = 0;
    int errors = 0;

    hcsr04_echo_emulator #(
        .TRIG_MIN_CYC (TMIN),
        .BURST_DLY_CYC(BDLY),
        .CYC_PER_CM   (CPC),
        .MAX_CM       (MAXC),
        .TIMEOUT_CYC  (TMO),
        .HOLDOFF_CYC  (HOLD)
    ) dut (
        .sys_clk50m(sys_clk50m),
        .sys_rst   (sys_rst),
        .trig      (trig),
        .dist_cm   (dist_cm),
        .echo      (echo),
        .busy      (busy),
        .trig_err  (trig_err),
        .dist_lat  (dist_lat)
    );

    always #5 sys_clk50m = ~sys_clk50m;

    // cyc = number of rising edges so far
    int cyc = 0;
    always @(posedge sys_clk50m) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge
    logic echo_q = 1'b0, busy_q = 1'b0, err_q = 1'b0;
    int t_rise = 0, t_fall = 0, t_bfall = 0;
    int n_rise = 0, n_fall = 0, n_bfall = 0, n_brise = 0, n_err = 0, n_err_cyc = 0;
    always @(negedge sys_clk50m) begin
        if (echo && !echo_q) begin t_rise <= cyc; n_rise <= n_rise + 1; end
        if (!echo && echo_q) begin t_fall <= cyc; n_fall <= n_fall + 1; end
        if (!busy && busy_q) begin t_bfall <= cyc; n_bfall <= n_bfall + 1; end
        if (busy && !busy_q) n_brise <= n_brise + 1;
        if (trig_err) n_err_cyc <= n_err_cyc + 1;
        if (trig_err && !err_q) n_err <= n_err + 1;
        echo_q <= echo;
        busy_q <= busy;
        err_q  <= trig_err;
    end

    int t_trig = 0;

    // Synchronized trig is high for exactly n cycles.
    task automatic pulse(input int n);
        @(negedge sys_clk50m);
        trig = 1'b1;
        repeat (n) @(negedge sys_clk50m);
        trig = 1'b0;
        t_trig = cyc;
    endtask

    // Full measurement; dist_cm is scrambled after acceptance.
    task automatic run_meas(input logic [15:0] d, input int n, output int tc, output bit ok);
        int start;
        start = n_bfall;
        dist_cm = d;
        pulse(n);
        tc = t_trig;
        repeat (5) @(negedge sys_clk50m);
        dist_cm = 16'hBEEF;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk50m);
            if (n_bfall != start) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge sys_clk50m);
    endtask

    task automatic wait_rise(input int start, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sys_clk50m);
            if (n_rise != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk50m);
            trig = ~trig;
            #2;
            checks++;
            if ({echo, busy, trig_err, dist_lat} !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs: got echo=%b busy=%b err=%b lat=%0d, want all 0",
                         echo, busy, trig_err, dist_lat);
            end
        end
        trig = 1'b0;
        @(negedge sys_clk50m);
        sys_rst = 1'b0;
        repeat (100) @(negedge sys_clk50m);
        checks++;
        if (n_rise !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: got rises=%0d busy=%b, want 0 0", n_rise, busy);
        end
    endtask

    task automatic test_nominal();
        int tc; bit ok; int e0;
        e0 = n_err;
        dist_cm = 16'd10;
        pulse(30);
        tc = t_trig;
        repeat (5) @(negedge sys_clk50m);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL nom_busy: got %b, want 1", busy);
        end
        dist_cm = 16'd33;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk50m);
            if (!busy) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge sys_clk50m);
        checks++;
        if (!ok) begin errors++; $display("FAIL nom_timeout: busy stuck, want low"); end
        checks++;
        if (t_rise - tc !== BDLY + 2) begin
            errors++; $display("FAIL nom_burst: got %0d, want %0d", t_rise - tc, BDLY + 2);
        end
        checks++;
        if (t_fall - t_rise !== 10 * CPC) begin
            errors++; $display("FAIL nom_width: got %0d, want %0d", t_fall - t_rise, 10 * CPC);
        end
        checks++;
        if (t_bfall - t_fall !== HOLD) begin
            errors++; $display("FAIL nom_holdoff: got %0d, want %0d", t_bfall - t_fall, HOLD);
        end
        checks++;
        if (dist_lat !== 16'd10) begin
            errors++; $display("FAIL nom_lat: got %0d, want 10", dist_lat);
        end
        checks++;
        if (n_err !== e0) begin
            errors++; $display("FAIL nom_err: got %0d errs, want %0d", n_err, e0);
        end
    endtask

    task automatic test_short();
        int r0, b0, e0, c0, tc; bit ok;
        r0 = n_rise; b0 = n_brise; e0 = n_err; c0 = n_err_cyc;
        dist_cm = 16'd3;
        pulse(TMIN - 1);
        repeat (20) @(negedge sys_clk50m);
        checks++;
        if (n_err - e0 !== 1 || n_err_cyc - c0 !== 1) begin
            errors++;
            $display("FAIL short_err: got pulses=%0d cycles=%0d, want 1 1", n_err - e0, n_err_cyc - c0);
        end
        checks++;
        if (n_rise !== r0 || n_brise !== b0 || busy !== 1'b0) begin
            errors++; $display("FAIL short_quiet: got rises=%0d busy_rises=%0d, want 0 0",
                               n_rise - r0, n_brise - b0);
        end
        // Exactly the minimum is accepted
        run_meas(16'd1, TMIN, tc, ok);
        checks++;
        if (!ok || t_fall - t_rise !== CPC || n_err - e0 !== 1) begin
            errors++; $display("FAIL min_accept: ok=%b width=%0d, want 1 %0d", ok, t_fall - t_rise, CPC);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] d_tab [4];
        int          w_tab [4];
        int tc; bit ok;
        d_tab = '{16'd0, 16'd40, 16'd41, 16'd500};
        w_tab = '{CPC, MAXC * CPC, TMO, TMO};
        for (int k = 0; k < 4; k++) begin
            run_meas(d_tab[k], 30, tc, ok);
            checks++;
            if (!ok || t_fall - t_rise !== w_tab[k]) begin
                errors++;
                $display("FAIL clamp_width d=%0d: ok=%b got %0d, want %0d",
                         d_tab[k], ok, t_fall - t_rise, w_tab[k]);
            end
            checks++;
            if (dist_lat !== d_tab[k]) begin
                errors++; $display("FAIL clamp_lat: got %0d, want %0d", dist_lat, d_tab[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int r0, b0, e0, f0, bf0, tc; bit ok;
        r0 = n_rise; b0 = n_brise; e0 = n_err;
        dist_cm = 16'd5;
        pulse(30);
        wait_rise(r0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_rise: no echo, want one"); end
        f0 = n_fall;
        pulse(25);                      // lands inside ECHO
        for (int i = 0; i < 200 && n_fall == f0; i++) @(negedge sys_clk50m);
        pulse(25);                      // lands inside HOLDOFF
        bf0 = n_bfall;
        @(negedge sys_clk50m);
        trig = 1'b1;                    // held high across the end of holdoff
        for (int i = 0; i < 300 && n_bfall == bf0; i++) @(negedge sys_clk50m);
        repeat (5) @(negedge sys_clk50m);
        trig = 1'b0;
        repeat (100) @(negedge sys_clk50m);
        checks++;
        if (n_rise - r0 !== 1 || n_brise - b0 !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_ignored: got rises=%0d busy_rises=%0d busy=%b, want 1 1 0",
                               n_rise - r0, n_brise - b0, busy);
        end
        checks++;
        if (n_err !== e0) begin
            errors++; $display("FAIL b2b_err: got %0d errs, want 0", n_err - e0);
        end
        run_meas(16'd12, 30, tc, ok);
        checks++;
        if (!ok || t_fall - t_rise !== 12 * CPC || t_rise - tc !== BDLY + 2) begin
            errors++; $display("FAIL b2b_next: ok=%b width=%0d lat=%0d, want 1 %0d %0d",
                               ok, t_fall - t_rise, t_rise - tc, 12 * CPC, BDLY + 2);
        end
    endtask

    task automatic test_reset_mid();
        int r0, tc; bit ok;
        r0 = n_rise;
        dist_cm = 16'd20;
        pulse(30);
        wait_rise(r0, ok);
        repeat (30) @(negedge sys_clk50m);
        checks++;
        if (echo !== 1'b1) begin errors++; $display("FAIL mid_echo_high: got %b, want 1", echo); end
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (echo !== 1'b0 || busy !== 1'b0 || dist_lat !== 16'd0) begin
            errors++; $display("FAIL mid_async: got echo=%b busy=%b lat=%0d, want 0 0 0",
                               echo, busy, dist_lat);
        end
        repeat (3) @(negedge sys_clk50m);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk50m);
        run_meas(16'd20, 30, tc, ok);
        checks++;
        if (!ok || t_fall - t_rise !== 20 * CPC) begin
            errors++; $display("FAIL mid_recover: ok=%b width=%0d, want 1 %0d", ok, t_fall - t_rise, 20 * CPC);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
